// File: rtl/toy_mem_pkg.sv
// Shared definitions for the RISC_TOY data-memory responder.
//   TOY_DW / TOY_AW : core data width and word-address width
//   TOY_RD / TOY_WR : encodings of the DRW request direction bit
//   resp_t          : one {valid,data} read-response stage
package toy_mem_pkg;

    localparam int unsigned TOY_DW = 32;
    localparam int unsigned TOY_AW = 30;

    localparam logic TOY_RD = 1'b0;
    localparam logic TOY_WR = 1'b1;

    typedef struct packed {
        logic              valid;
        logic [TOY_DW-1:0] data;
    } resp_t;

endpackage

// File: rtl/toy_dmem_responder_if.sv
// Core data-port bundle between the RISC_TOY core and its data memory.
//   master (core)  : drives DREQ, DRW, DADDR, DWDATA; receives DRDATA, DRVALID, DERR
//   slave (memory) : the mirror image
interface toy_dmem_responder_if;
    import toy_mem_pkg::*;

    logic              DREQ;
    logic              DRW;
    logic [TOY_AW-1:0] DADDR;
    logic [TOY_DW-1:0] DWDATA;
    logic [TOY_DW-1:0] DRDATA;
    logic              DRVALID;
    logic              DERR;

    modport master (
        output DREQ, DRW, DADDR, DWDATA,
        input  DRDATA, DRVALID, DERR
    );

    modport slave (
        input  DREQ, DRW, DADDR, DWDATA,
        output DRDATA, DRVALID, DERR
    );

endinterface

// File: rtl/toy_resp_pipe.sv
// Read-response delay line: DEPTH stages of {valid,data}.
//   clk_i, rst_i       : clock, asynchronous active-high reset (valid bits only)
//   valid_i, data_i    : response entering the line
//   valid_o, data_o    : response leaving the line; data_o holds while valid_o=0
// Only used with DEPTH >= 1.
module toy_resp_pipe #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned DW    = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          valid_i,
    input  logic [DW-1:0] data_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o
);

    logic [DEPTH-1:0]         vld_q;
    logic [DEPTH-1:0][DW-1:0] dat_q;
    logic                     seen_q;  // last stage has carried a response since reset

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q  <= '0;
            seen_q <= 1'b0;
        end else begin
            vld_q[0] <= valid_i;
            for (int i = 1; i < int'(DEPTH); i++) begin
                vld_q[i] <= vld_q[i-1];
            end
            if (vld_q[DEPTH-1]) seen_q <= 1'b1;
        end
    end

    // Data only moves with a valid, so the output stage keeps the last response.
    always_ff @(posedge clk_i) begin
        if (valid_i) dat_q[0] <= data_i;
        for (int i = 1; i < int'(DEPTH); i++) begin
            if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
        end
    end

    assign valid_o = vld_q[DEPTH-1];
    // Unreset data is masked to zero until the first response arrives after reset.
    assign data_o  = (seen_q || vld_q[DEPTH-1]) ? dat_q[DEPTH-1] : '0;

endmodule

// File: rtl/toy_dmem_responder.sv
// Data-memory responder for the RISC_TOY core: one request per cycle, no backpressure,
// fixed read latency RD_LAT (1..4), writes committed on the request edge.
//   CLK, RST       : clock, asynchronous active-high reset
//   bus (slave)    : DREQ/DRW/DADDR/DWDATA in, DRDATA/DRVALID/DERR out
//   RD_CNT, WR_CNT : saturating in-range read/write counters, only with DMEM_STATS_EN defined
// Out-of-range accesses (DADDR above 2**AW words) set sticky DERR; reads return 0,
// writes are dropped.
module toy_dmem_responder
    import toy_mem_pkg::*;
#(
    parameter int unsigned AW     = 10,
    parameter int unsigned DW     = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic CLK,
    input  logic RST,
    toy_dmem_responder_if.slave bus
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0] RD_CNT,
    output logic [15:0] WR_CNT
`endif
);

    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
        $error("toy_dmem_responder: RD_LAT=%0d outside 1..4", RD_LAT);
    end
    if (DW != TOY_DW) begin : g_bad_dw
        $error("toy_dmem_responder: DW must be %0d", TOY_DW);
    end

    localparam int unsigned Words = 1 << AW;

    logic [DW-1:0] mem [Words];
    logic [AW-1:0] idx;
    logic          in_range;
    logic          rd_req;
    logic          wr_req;
    resp_t         stage0_q;
    logic          derr_q;

    assign idx    = bus.DADDR[AW-1:0];
    assign rd_req = bus.DREQ && (bus.DRW == TOY_RD);
    assign wr_req = bus.DREQ && (bus.DRW == TOY_WR);

    if (AW < TOY_AW) begin : g_rng
        assign in_range = (bus.DADDR[TOY_AW-1:AW] == '0);
    end else begin : g_full
        assign in_range = 1'b1;
    end

    // A write on an edge where RST is high must not land.
    always_ff @(posedge CLK) begin
        if (!RST && wr_req && in_range) mem[idx] <= bus.DWDATA;
    end

    // Stage 0: registered array output; samples the array before this edge's write.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stage0_q <= '0;
        end else begin
            stage0_q.valid <= rd_req;
            if (rd_req) stage0_q.data <= in_range ? mem[idx] : '0;
        end
    end

    if (RD_LAT > 1) begin : g_pipe
        toy_resp_pipe #(
            .DEPTH (RD_LAT - 1),
            .DW    (DW)
        ) u_pipe (
            .clk_i   (CLK),
            .rst_i   (RST),
            .valid_i (stage0_q.valid),
            .data_i  (stage0_q.data),
            .valid_o (bus.DRVALID),
            .data_o  (bus.DRDATA)
        );
    end else begin : g_direct
        assign bus.DRVALID = stage0_q.valid;
        assign bus.DRDATA  = stage0_q.data;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            derr_q <= 1'b0;
        end else if (bus.DREQ && !in_range) begin
            derr_q <= 1'b1;
        end
    end
    assign bus.DERR = derr_q;

`ifdef DMEM_STATS_EN
    logic [15:0] rd_cnt_q;
    logic [15:0] wr_cnt_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            if (rd_req && in_range && rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
            if (wr_req && in_range && wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
        end
    end
    assign RD_CNT = rd_cnt_q;
    assign WR_CNT = wr_cnt_q;
`endif

endmodule

// File: tb/tb_toy_dmem_responder.sv
// Bench for toy_dmem_responder: two instances (RD_LAT=1 and RD_LAT=3) share one stimulus
// stream; per-instance scoreboards hold {expected data, expected cycle}.
module tb_toy_dmem_responder;
    import toy_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dreq = 1'b0;
    logic        drw = 1'b0;
    logic [29:0] daddr = '0;
    logic [31:0] dwdata = '0;

    always #5 clk = ~clk;

    toy_dmem_responder_if bus1 ();
    toy_dmem_responder_if bus3 ();

    assign bus1.DREQ   = dreq;
    assign bus1.DRW    = drw;
    assign bus1.DADDR  = daddr;
    assign bus1.DWDATA = dwdata;
    assign bus3.DREQ   = dreq;
    assign bus3.DRW    = drw;
    assign bus3.DADDR  = daddr;
    assign bus3.DWDATA = dwdata;

`ifdef DMEM_STATS_EN
    logic [15:0] rc1, wc1, rc3, wc3;
`endif

    toy_dmem_responder #(.AW(10), .DW(32), .RD_LAT(1)) u_dut1 (
        .CLK (clk),
        .RST (rst),
        .bus (bus1)
`ifdef DMEM_STATS_EN
        ,
        .RD_CNT (rc1),
        .WR_CNT (wc1)
`endif
    );

    toy_dmem_responder #(.AW(10), .DW(32), .RD_LAT(3)) u_dut3 (
        .CLK (clk),
        .RST (rst),
        .bus (bus3)
`ifdef DMEM_STATS_EN
        ,
        .RD_CNT (rc3),
        .WR_CNT (wc3)
`endif
    );

    // Reference state
    logic [31:0] model [1024];
    logic [31:0] qd1[$], qd3[$];
    int          qc1[$], qc3[$];
    logic [31:0] last1 = '0, last3 = '0;
    int          derr_cyc = -1;
    int          rd_m = 0, wr_m = 0;
    int          cyc = 0;
    int          total = 0, bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, exp);
        end
    endtask

    // Issue one request at the coming edge and record its expected effect.
    task automatic issue(input logic rw, input logic [29:0] a, input logic [31:0] d);
        logic        inr;
        logic [31:0] e;
        inr    = (a[29:10] == 20'd0);
        dreq   = 1'b1;
        drw    = rw;
        daddr  = a;
        dwdata = d;
        if (!inr && derr_cyc < 0) derr_cyc = cyc + 1;
        if (rw == TOY_RD) begin
            e = inr ? model[a[9:0]] : 32'h0;
            qd1.push_back(e); qc1.push_back(cyc + 1);
            qd3.push_back(e); qc3.push_back(cyc + 3);
            if (inr && rd_m < 65535) rd_m++;
        end else if (inr) begin
            model[a[9:0]] = d;
            if (wr_m < 65535) wr_m++;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        dreq   = 1'b0;
        drw    = 1'($urandom);
        daddr  = 30'($urandom);
        dwdata = $urandom;
        repeat (n) @(negedge clk);
    endtask

    // Reset with two reads in flight and a write presented on the reset edge.
    task automatic do_reset();
        rst    = 1'b1;
        dreq   = 1'b1;
        drw    = TOY_WR;
        daddr  = 30'd9;
        dwdata = 32'hBAD0_0009;
        qd1.delete(); qc1.delete(); qd3.delete(); qc3.delete();
        last1 = '0; last3 = '0; derr_cyc = -1; rd_m = 0; wr_m = 0;
        @(negedge clk);
        dreq = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Scoreboard monitors, sampled 1 time unit after the falling edge.
    always @(negedge clk) begin
        logic [31:0] d;
        int          c;
        #1;
        if (rst) begin
            chk("rst_valid1", 32'(bus1.DRVALID), 32'd0);
            chk("rst_data1", bus1.DRDATA, 32'd0);
            chk("rst_valid3", 32'(bus3.DRVALID), 32'd0);
            chk("rst_data3", bus3.DRDATA, 32'd0);
            chk("rst_derr", 32'(bus3.DERR), 32'd0);
        end else begin
            chk("derr1", 32'(bus1.DERR), 32'(derr_cyc >= 0 && cyc >= derr_cyc));
            chk("derr3", 32'(bus3.DERR), 32'(derr_cyc >= 0 && cyc >= derr_cyc));
            if (bus1.DRVALID === 1'b1) begin
                if (qd1.size() == 0) begin
                    chk("unexpected1", 32'd1, 32'd0);
                end else begin
                    d = qd1.pop_front(); c = qc1.pop_front();
                    chk("rd1_data", bus1.DRDATA, d);
                    chk("rd1_time", 32'(cyc), 32'(c));
                    last1 = d;
                end
            end else begin
                chk("hold1", bus1.DRDATA, last1);
                if (qc1.size() > 0 && qc1[0] <= cyc) begin
                    chk("missing1", 32'd0, 32'd1);
                    void'(qd1.pop_front()); void'(qc1.pop_front());
                end
            end
            if (bus3.DRVALID === 1'b1) begin
                if (qd3.size() == 0) begin
                    chk("unexpected3", 32'd1, 32'd0);
                end else begin
                    d = qd3.pop_front(); c = qc3.pop_front();
                    chk("rd3_data", bus3.DRDATA, d);
                    chk("rd3_time", 32'(cyc), 32'(c));
                    last3 = d;
                end
            end else begin
                chk("hold3", bus3.DRDATA, last3);
                if (qc3.size() > 0 && qc3[0] <= cyc) begin
                    chk("missing3", 32'd0, 32'd1);
                    void'(qd3.pop_front()); void'(qc3.pop_front());
                end
            end
        end
    end

    initial begin
        logic [29:0] a;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Fill the array so every read has a defined expectation.
        for (int i = 0; i < 1024; i++) issue(TOY_WR, 30'(i), $urandom);
        idle(2);

        // Write then read word 4.
        issue(TOY_WR, 30'h4, 32'hDEAD_BEEF);
        issue(TOY_RD, 30'h4, '0);
        idle(4);

        // Back-to-back reads 0..7.
        for (int i = 0; i < 8; i++) issue(TOY_RD, 30'(i), '0);
        idle(5);

        // Read in flight keeps the old value; later read sees the new one.
        issue(TOY_WR, 30'h5, 32'h11);
        idle(1);
        issue(TOY_RD, 30'h5, '0);
        issue(TOY_WR, 30'h5, 32'h22);
        issue(TOY_RD, 30'h5, '0);
        idle(5);

        // Out-of-range read and write.
        issue(TOY_RD, 30'h400, '0);
        issue(TOY_WR, 30'h400, 32'hCAFE_F00D);
        issue(TOY_RD, 30'h0, '0);
        idle(5);

        // Reset with reads in flight.
        issue(TOY_RD, 30'h1, '0);
        issue(TOY_RD, 30'h2, '0);
        do_reset();
        idle(6);
        issue(TOY_RD, 30'h9, '0);
        idle(4);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                idle(1);
            end else begin
                if ($urandom_range(0, 9) == 0) a = {20'($urandom_range(1, 20'hFFFFF)), 10'($urandom)};
                else a = 30'($urandom_range(0, 1023));
                issue(1'($urandom), a, $urandom);
            end
        end
        idle(6);

`ifdef DMEM_STATS_EN
        do_reset();
        idle(1);
        for (int i = 0; i < 3; i++) issue(TOY_RD, 30'(i + 16), '0);
        for (int i = 0; i < 2; i++) issue(TOY_WR, 30'(i + 32), $urandom);
        issue(TOY_RD, 30'h0800, '0);
        idle(5);
        chk("rd_cnt1", 32'(rc1), 32'(rd_m));
        chk("wr_cnt1", 32'(wc1), 32'(wr_m));
        chk("rd_cnt3", 32'(rc3), 32'(rd_m));
        chk("wr_cnt3", 32'(wc3), 32'(wr_m));
        for (int i = 0; i < 66000; i++) issue(TOY_RD, 30'($urandom_range(0, 1023)), '0);
        idle(5);
        chk("rd_sat1", 32'(rc1), 32'(rd_m));
        chk("rd_sat3", 32'(rc3), 32'(rd_m));
        chk("wr_hold1", 32'(wc1), 32'(wr_m));
`endif

        chk("drain1", 32'(qd1.size()), 32'd0);
        chk("drain3", 32'(qd3.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
